// File: rtl/gray_sr_sequencer.sv
// Sequences a bank of SR flip-flops through a reflected Gray code, up or down.
// Each step drives one excitation cycle, then verifies the bank's Q readback
// against the internal model; any mismatch halts with a sticky error.
module gray_sr_sequencer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 load_i,
  input  logic                 dir_i,
  input  logic [7:0]           steps_i,
  input  logic [WIDTH-1:0]     load_val_i,
  input  logic [WIDTH-1:0]     q_i,
  output logic [2*WIDTH-1:0]   sr_o,
  output logic [WIDTH-1:0]     expected_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StCheck = 2'd2;
  localparam logic [1:0] StHalt  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic [WIDTH-1:0]   target_q, target_d;
  logic [7:0]         remaining_q, remaining_d;
  logic               op_load_q, op_load_d;
  logic               dir_q, dir_d;
  logic               stop_pend_q, stop_pend_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   idle_next;
  logic [WIDTH-1:0]   run_next;

  // Gray -> binary, +/-1 modulo 2^WIDTH, binary -> Gray.
  function automatic logic [WIDTH-1:0] gray_step(input logic [WIDTH-1:0] g, input logic up);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    b = up ? b + WIDTH'(1) : b - WIDTH'(1);
    return b ^ (b >> 1);
  endfunction

  // Set only bits going 0->1, reset only bits going 1->0; S and R never both high.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t);
    logic [2*WIDTH-1:0] e;
    e = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      e[2*i+1] = ~q[i] & t[i];
      e[2*i]   = q[i] & ~t[i];
    end
    return e;
  endfunction

  assign idle_next = gray_step(expected_q, dir_i);
  assign run_next  = gray_step(target_q, dir_q);

  // Next-state logic: command acceptance, step issue and readback check.
  always_comb begin
    state_d     = state_q;
    sr_d        = '0;
    expected_d  = expected_q;
    target_d    = target_q;
    remaining_d = remaining_q;
    op_load_d   = op_load_q;
    dir_d       = dir_q;
    stop_pend_d = stop_pend_q;
    done_d      = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        stop_pend_d = 1'b0;
        if (load_i) begin
          target_d  = load_val_i;
          op_load_d = 1'b1;
          sr_d      = excite(q_i, load_val_i);
          state_d   = StIssue;
        end else if (start_i) begin
          target_d    = idle_next;
          remaining_d = steps_i;
          dir_d       = dir_i;
          op_load_d   = 1'b0;
          sr_d        = excite(q_i, idle_next);
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (stop_i) stop_pend_d = 1'b1;
        state_d = StCheck;
      end
      StCheck: begin
        if (stop_i) stop_pend_d = 1'b1;
        if (q_i != target_q) begin
          err_d       = 1'b1;
          stop_pend_d = 1'b0;
          state_d     = StHalt;
        end else begin
          expected_d = target_q;
          if (op_load_q || stop_pend_q || remaining_q == 8'd1) begin
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
            state_d     = StIdle;
          end else begin
            // remaining == 0 means free-run: never decremented, never reaches 1
            if (remaining_q != 8'd0) remaining_d = remaining_q - 8'd1;
            target_d = run_next;
            sr_d     = excite(q_i, run_next);
            state_d  = StIssue;
          end
        end
      end
      StHalt: begin
        if (load_i) begin
          err_d     = 1'b0;
          target_d  = load_val_i;
          op_load_d = 1'b1;
          sr_d      = excite(q_i, load_val_i);
          state_d   = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset forces sr to hold immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      expected_q  <= '0;
      target_q    <= '0;
      remaining_q <= '0;
      op_load_q   <= 1'b0;
      dir_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      expected_q  <= expected_d;
      target_q    <= target_d;
      remaining_q <= remaining_d;
      op_load_q   <= op_load_d;
      dir_q       <= dir_d;
      stop_pend_q <= stop_pend_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign sr_o       = sr_q;
  assign expected_o = expected_q;
  assign busy_o     = (state_q == StIssue) || (state_q == StCheck);
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_gray_sr_sequencer.sv
// Directed bench: drives the sequencer against a behavioural SR flip-flop bank
// with an optional stuck-at-0 mask, checking hand-computed values.
module tb_gray_sr_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_i, stop_i, load_i, dir_i;
  logic [7:0] steps_i;
  logic [3:0] load_val_i;
  logic [3:0] bank;
  logic [3:0] stuck0;
  logic [7:0] sr_o;
  logic [3:0] expected_o;
  logic       busy_o, done_o, err_o;

  int unsigned n_checks;
  int unsigned n_errors;

  gray_sr_sequencer #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .load_i     (load_i),
    .dir_i      (dir_i),
    .steps_i    (steps_i),
    .load_val_i (load_val_i),
    .q_i        (bank),
    .sr_o       (sr_o),
    .expected_o (expected_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sr_apply(input logic [3:0] b, input logic [7:0] e);
    logic [3:0] n;
    n = b;
    for (int i = 0; i < 4; i++) begin
      if (e[2*i+1]) n[i] = 1'b1;
      else if (e[2*i]) n[i] = 1'b0;
    end
    return n;
  endfunction

  // SR flip-flop bank, no reset
  always @(posedge clk) bank <= sr_apply(bank, sr_o) & ~stuck0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [3:0] val);
    load_i = 1'b1; load_val_i = val;
    tick(); load_i = 1'b0;
    tick(); tick();
    check_eq("load_done", {31'd0, done_o}, 32'd1);
    check_eq("load_exp", {28'd0, expected_o}, {28'd0, val});
    tick();
  endtask

  logic [7:0] up_sr [4];
  logic [3:0] up_q  [4];
  logic [7:0] dn_sr [2];
  logic [3:0] dn_q  [2];

  initial begin
    up_sr = '{8'h02, 8'h08, 8'h01, 8'h20};
    up_q  = '{4'h1, 4'h3, 4'h2, 4'h6};
    dn_sr = '{8'h80, 8'h02};
    dn_q  = '{4'h8, 4'h9};
    n_checks = 0; n_errors = 0;
    clk = 1'b0; rst_n = 1'b0;
    start_i = 0; stop_i = 0; load_i = 0; dir_i = 0; steps_i = 0; load_val_i = 0;
    bank = 4'h0; stuck0 = 4'h0;

    // Reset values, during and one cycle after release
    tick();
    check_eq("rst_sr", {24'd0, sr_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    check_eq("rst_err", {31'd0, err_o}, 32'd0);
    check_eq("rst_exp", {28'd0, expected_o}, 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_sr", {24'd0, sr_o}, 32'd0);
    check_eq("post_rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("post_rst_done", {31'd0, done_o}, 32'd0);

    // Load 0110 from 0000
    load_i = 1'b1; load_val_i = 4'b0110;
    tick(); load_i = 1'b0;
    check_eq("ld_sr", {24'd0, sr_o}, 32'h28);
    check_eq("ld_busy", {31'd0, busy_o}, 32'd1);
    tick();
    check_eq("ld_sr_hold", {24'd0, sr_o}, 32'd0);
    check_eq("ld_q", {28'd0, bank}, 32'h6);
    tick();
    check_eq("ld_done", {31'd0, done_o}, 32'd1);
    check_eq("ld_exp", {28'd0, expected_o}, 32'h6);
    check_eq("ld_busy_off", {31'd0, busy_o}, 32'd0);
    tick();
    check_eq("ld_done_pulse", {31'd0, done_o}, 32'd0);
    do_load(4'h0);

    // Count up 4 steps
    start_i = 1'b1; dir_i = 1'b1; steps_i = 8'd4;
    tick(); start_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_eq("up_sr", {24'd0, sr_o}, {24'd0, up_sr[k]});
      check_eq("up_busy", {31'd0, busy_o}, 32'd1);
      check_eq("up_nodone", {31'd0, done_o}, 32'd0);
      tick();
      check_eq("up_sr_zero", {24'd0, sr_o}, 32'd0);
      check_eq("up_q", {28'd0, bank}, {28'd0, up_q[k]});
      tick();
    end
    check_eq("up_done", {31'd0, done_o}, 32'd1);
    check_eq("up_busy_off", {31'd0, busy_o}, 32'd0);
    check_eq("up_exp", {28'd0, expected_o}, 32'h6);
    tick();
    do_load(4'h0);

    // Count down 2 steps, wrapping through zero
    start_i = 1'b1; dir_i = 1'b0; steps_i = 8'd2;
    tick(); start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check_eq("dn_sr", {24'd0, sr_o}, {24'd0, dn_sr[k]});
      tick();
      check_eq("dn_q", {28'd0, bank}, {28'd0, dn_q[k]});
      tick();
    end
    check_eq("dn_done", {31'd0, done_o}, 32'd1);
    check_eq("dn_exp", {28'd0, expected_o}, 32'h9);
    tick();
    do_load(4'h0);

    // Free-run, stop during third ISSUE
    start_i = 1'b1; dir_i = 1'b1; steps_i = 8'd0;
    tick(); start_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_eq("fr_sr", {24'd0, sr_o}, {24'd0, up_sr[k]});
      if (k == 2) stop_i = 1'b1;
      tick(); stop_i = 1'b0;
      check_eq("fr_q", {28'd0, bank}, {28'd0, up_q[k]});
      tick();
    end
    check_eq("fr_done", {31'd0, done_o}, 32'd1);
    check_eq("fr_busy_off", {31'd0, busy_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("fr_quiet_sr", {24'd0, sr_o}, 32'd0);
      check_eq("fr_quiet_q", {28'd0, bank}, 32'h2);
    end

    // Start and load together: load wins
    start_i = 1'b1; load_i = 1'b1; load_val_i = 4'h0; dir_i = 1'b1; steps_i = 8'd3;
    tick(); start_i = 1'b0; load_i = 1'b0;
    check_eq("sl_sr", {24'd0, sr_o}, 32'h04);
    tick(); tick();
    check_eq("sl_done", {31'd0, done_o}, 32'd1);
    check_eq("sl_exp", {28'd0, expected_o}, 32'h0);
    tick();
    check_eq("sl_no_start", {31'd0, busy_o}, 32'd0);
    check_eq("sl_sr_idle", {24'd0, sr_o}, 32'd0);

    // Stuck-at-0 bit 0: mismatch, halt, start ignored, load recovers
    stuck0 = 4'b0001;
    start_i = 1'b1; dir_i = 1'b1; steps_i = 8'd3;
    tick(); start_i = 1'b0;
    check_eq("st_sr", {24'd0, sr_o}, 32'h02);
    tick();
    check_eq("st_q", {28'd0, bank}, 32'h0);
    tick();
    check_eq("st_err", {31'd0, err_o}, 32'd1);
    check_eq("st_busy", {31'd0, busy_o}, 32'd0);
    check_eq("st_sr_halt", {24'd0, sr_o}, 32'd0);
    check_eq("st_nodone", {31'd0, done_o}, 32'd0);
    check_eq("st_exp", {28'd0, expected_o}, 32'h0);
    start_i = 1'b1;
    tick(); start_i = 1'b0;
    check_eq("st_start_ign", {31'd0, busy_o}, 32'd0);
    check_eq("st_err_stick", {31'd0, err_o}, 32'd1);
    stuck0 = 4'h0;
    load_i = 1'b1; load_val_i = 4'h0;
    tick(); load_i = 1'b0;
    check_eq("st_ld_busy", {31'd0, busy_o}, 32'd1);
    tick(); tick();
    check_eq("st_ld_done", {31'd0, done_o}, 32'd1);
    check_eq("st_err_clr", {31'd0, err_o}, 32'd0);
    tick();

    // Async reset mid-step
    start_i = 1'b1; dir_i = 1'b1; steps_i = 8'd1;
    tick(); start_i = 1'b0;
    check_eq("mr_sr", {24'd0, sr_o}, 32'h02);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mr_sr_zero", {24'd0, sr_o}, 32'd0);
    check_eq("mr_busy", {31'd0, busy_o}, 32'd0);
    tick();
    check_eq("mr_q_hold", {28'd0, bank}, 32'h0);
    rst_n = 1'b1;
    tick();
    check_eq("mr_idle", {31'd0, busy_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
